// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_pkg
//  Purpose  : Shared constants for the JTAG master: TAP state encodings,
//             command codes, control FSM states and the TAP next-state table.
//  Revision : 1.0  initial release
// ============================================================================
package jtag_pkg;

   // TAP controller states, IEEE 1149.1 encoding
   localparam logic [3:0] c_tap_tlr      = 4'hF;
   localparam logic [3:0] c_tap_rti      = 4'hC;
   localparam logic [3:0] c_tap_sel_dr   = 4'h7;
   localparam logic [3:0] c_tap_cap_dr   = 4'h6;
   localparam logic [3:0] c_tap_sh_dr    = 4'h2;
   localparam logic [3:0] c_tap_ex1_dr   = 4'h1;
   localparam logic [3:0] c_tap_pause_dr = 4'h3;
   localparam logic [3:0] c_tap_ex2_dr   = 4'h0;
   localparam logic [3:0] c_tap_upd_dr   = 4'h5;
   localparam logic [3:0] c_tap_sel_ir   = 4'h4;
   localparam logic [3:0] c_tap_cap_ir   = 4'hE;
   localparam logic [3:0] c_tap_sh_ir    = 4'hA;
   localparam logic [3:0] c_tap_ex1_ir   = 4'h9;
   localparam logic [3:0] c_tap_pause_ir = 4'hB;
   localparam logic [3:0] c_tap_ex2_ir   = 4'h8;
   localparam logic [3:0] c_tap_upd_ir   = 4'hD;

   // Command codes on cmd_type
   localparam logic [1:0] c_cmd_reset = 2'd0;
   localparam logic [1:0] c_cmd_idle  = 2'd1;
   localparam logic [1:0] c_cmd_ir    = 2'd2;
   localparam logic [1:0] c_cmd_dr    = 2'd3;

   // Control FSM states
   typedef enum logic [2:0] {
      c_st_init_rst = 3'd0,
      c_st_ready    = 3'd1,
      c_st_hdr      = 3'd2,
      c_st_shift    = 3'd3,
      c_st_tail     = 3'd4,
      c_st_idle_run = 3'd5,
      c_st_resp     = 3'd6
   } ctl_state_t;

   // TAP state after one TCK rising edge with the given TMS
   function automatic logic [3:0] tap_next(input logic [3:0] state, input logic tms);
      logic [3:0] nxt;
      case (state)
         c_tap_tlr      : nxt = tms ? c_tap_tlr    : c_tap_rti;
         c_tap_rti      : nxt = tms ? c_tap_sel_dr : c_tap_rti;
         c_tap_sel_dr   : nxt = tms ? c_tap_sel_ir : c_tap_cap_dr;
         c_tap_cap_dr   : nxt = tms ? c_tap_ex1_dr : c_tap_sh_dr;
         c_tap_sh_dr    : nxt = tms ? c_tap_ex1_dr : c_tap_sh_dr;
         c_tap_ex1_dr   : nxt = tms ? c_tap_upd_dr : c_tap_pause_dr;
         c_tap_pause_dr : nxt = tms ? c_tap_ex2_dr : c_tap_pause_dr;
         c_tap_ex2_dr   : nxt = tms ? c_tap_upd_dr : c_tap_sh_dr;
         c_tap_upd_dr   : nxt = tms ? c_tap_sel_dr : c_tap_rti;
         c_tap_sel_ir   : nxt = tms ? c_tap_tlr    : c_tap_cap_ir;
         c_tap_cap_ir   : nxt = tms ? c_tap_ex1_ir : c_tap_sh_ir;
         c_tap_sh_ir    : nxt = tms ? c_tap_ex1_ir : c_tap_sh_ir;
         c_tap_ex1_ir   : nxt = tms ? c_tap_upd_ir : c_tap_pause_ir;
         c_tap_pause_ir : nxt = tms ? c_tap_ex2_ir : c_tap_pause_ir;
         c_tap_ex2_ir   : nxt = tms ? c_tap_upd_ir : c_tap_sh_ir;
         default        : nxt = tms ? c_tap_sel_dr : c_tap_rti;  // update-IR
      endcase
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_tck_gen
//  Purpose  : Divides clk into TCK (DIV clk cycles per half period) while en
//             is high, with one-cycle strobes marking the clk edge on which
//             TCK rises or falls. TCK parks low when disabled.
//  Revision : 1.0  initial release
// ============================================================================
module jtag_tck_gen #(
   parameter int DIV = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tck,
   output logic tck_rise,
   output logic tck_fall
);

   localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] c_last = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tck;
   logic          w_edge;

   // The next clk edge toggles TCK when the half-period counter is exhausted
   assign w_edge   = en && (r_cnt == c_last);
   assign tck_rise = w_edge && !r_tck;
   assign tck_fall = w_edge &&  r_tck;
   assign tck      = r_tck;

   // Half-period counter and TCK toggle; disabling restarts from a low phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (!en) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (w_edge) begin
         r_cnt <= '0;
         r_tck <= ~r_tck;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_master
//  Purpose  : Command-driven JTAG TAP driver. Runs TAP reset, idle, IR-scan
//             and DR-scan sequences from a valid/ready command port, drives
//             TCK/TMS/TDI/TRST, captures TDO and returns it on a response port.
//  Revision : 1.0  initial release
// ============================================================================
module jtag_master
   import jtag_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int DIV     = 4,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_type,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic [3:0]         tap_state,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   output logic               trst,
   input  logic               tdo
);

   localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

   ctl_state_t         r_state, w_state_nxt;
   logic [2:0]         r_step, w_step_nxt;
   logic [LEN_W-1:0]   r_bit, w_bit_nxt;
   logic [LEN_W-1:0]   r_len;
   logic               r_is_ir, r_cmd_reset;
   logic               r_tms, w_tms_nxt;
   logic               r_tdi, w_tdi_nxt;
   logic               r_trst, w_trst_nxt;
   logic [3:0]         r_tap_state;
   logic [MAX_LEN-1:0] r_tdi_sr, r_tdo_sr, r_rsp_data;
   logic               w_accept, w_finish_scan;
   logic               w_run, w_rise, w_fall;
   logic [LEN_W-1:0]   w_len_clamped;
   logic [2:0]         w_hdr_last;

   assign cmd_ready = (r_state == c_st_ready);
   assign rsp_valid = (r_state == c_st_resp);
   assign rsp_data  = r_rsp_data;
   assign tap_state = r_tap_state;
   assign tms       = r_tms;
   assign tdi       = r_tdi;
   assign trst      = r_trst;

   assign w_len_clamped = (cmd_len > c_max_len) ? c_max_len : cmd_len;
   // Preamble is SelDR,SelIR,CapIR,ShIR for IR and SelDR,CapDR,ShDR for DR
   assign w_hdr_last    = r_is_ir ? 3'd3 : 3'd2;
   assign w_run         = (r_state == c_st_init_rst) || (r_state == c_st_hdr) ||
                          (r_state == c_st_shift)    || (r_state == c_st_tail) ||
                          (r_state == c_st_idle_run);

   jtag_tck_gen #(
      .DIV      (DIV)
   ) u_tck_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_run),
      .tck      (tck),
      .tck_rise (w_rise),
      .tck_fall (w_fall)
   );

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_st_init_rst;
      else        r_state <= w_state_nxt;
   end

   // Next state and next pin values; pins only change on the TCK-fall edge
   always_comb begin
      w_state_nxt   = r_state;
      w_step_nxt    = r_step;
      w_bit_nxt     = r_bit;
      w_tms_nxt     = r_tms;
      w_tdi_nxt     = r_tdi;
      w_trst_nxt    = r_trst;
      w_accept      = 1'b0;
      w_finish_scan = 1'b0;
      case (r_state)
         c_st_init_rst: begin
            if (w_fall) begin
               w_trst_nxt = 1'b0;
               if (r_step == 3'd5) begin
                  w_state_nxt = r_cmd_reset ? c_st_resp : c_st_ready;
                  w_tms_nxt   = 1'b0;
               end else begin
                  w_step_nxt = r_step + 3'd1;
                  w_tms_nxt  = (r_step != 3'd4);
               end
            end
         end
         c_st_ready: begin
            if (cmd_valid) begin
               w_accept   = 1'b1;
               w_step_nxt = 3'd0;
               w_bit_nxt  = '0;
               w_tdi_nxt  = 1'b0;
               case (cmd_type)
                  c_cmd_reset: begin
                     w_state_nxt = c_st_init_rst;
                     w_tms_nxt   = 1'b1;
                     w_trst_nxt  = 1'b1;
                  end
                  c_cmd_idle: begin
                     w_state_nxt = (cmd_len == '0) ? c_st_resp : c_st_idle_run;
                     w_tms_nxt   = 1'b0;
                  end
                  default: begin
                     w_state_nxt = (w_len_clamped == '0) ? c_st_resp : c_st_hdr;
                     w_tms_nxt   = (w_len_clamped != '0);
                  end
               endcase
            end
         end
         c_st_hdr: begin
            if (w_fall) begin
               if (r_step == w_hdr_last) begin
                  w_state_nxt = c_st_shift;
                  w_bit_nxt   = '0;
                  w_tms_nxt   = (r_len == LEN_W'(1));
                  w_tdi_nxt   = r_tdi_sr[0];
               end else begin
                  w_step_nxt = r_step + 3'd1;
                  w_tms_nxt  = r_is_ir && (r_step == 3'd0);
               end
            end
         end
         c_st_shift: begin
            if (w_fall) begin
               if (r_bit == r_len - LEN_W'(1)) begin
                  w_state_nxt = c_st_tail;
                  w_step_nxt  = 3'd0;
                  w_tms_nxt   = 1'b1;
                  w_tdi_nxt   = 1'b0;
               end else begin
                  w_bit_nxt = r_bit + LEN_W'(1);
                  w_tms_nxt = (r_bit + LEN_W'(2) == r_len);
                  w_tdi_nxt = r_tdi_sr[0];
               end
            end
         end
         c_st_tail: begin
            if (w_fall) begin
               w_tms_nxt = 1'b0;
               if (r_step == 3'd1) begin
                  w_state_nxt   = c_st_resp;
                  w_finish_scan = 1'b1;
               end else begin
                  w_step_nxt = 3'd1;
               end
            end
         end
         c_st_idle_run: begin
            if (w_fall) begin
               if (r_bit == r_len - LEN_W'(1)) w_state_nxt = c_st_resp;
               else                            w_bit_nxt   = r_bit + LEN_W'(1);
            end
         end
         c_st_resp: begin
            if (rsp_ready) w_state_nxt = c_st_ready;
         end
         default: w_state_nxt = c_st_init_rst;
      endcase
   end

   // Datapath: pin registers, TAP tracking, TDI/TDO shifters and response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step      <= '0;
         r_bit       <= '0;
         r_len       <= '0;
         r_is_ir     <= 1'b0;
         r_cmd_reset <= 1'b0;
         r_tms       <= 1'b1;
         r_tdi       <= 1'b0;
         r_trst      <= 1'b0;
         r_tap_state <= c_tap_tlr;
         r_tdi_sr    <= '0;
         r_tdo_sr    <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_step <= w_step_nxt;
         r_bit  <= w_bit_nxt;
         r_tms  <= w_tms_nxt;
         r_tdi  <= w_tdi_nxt;
         r_trst <= w_trst_nxt;
         if (w_accept) begin
            r_is_ir     <= (cmd_type == c_cmd_ir);
            r_cmd_reset <= (cmd_type == c_cmd_reset);
            r_len       <= (cmd_type == c_cmd_idle) ? cmd_len : w_len_clamped;
            r_tdi_sr    <= cmd_data;
            r_tdo_sr    <= '0;
            r_rsp_data  <= '0;
         end
         if (w_rise) begin
            r_tap_state <= r_trst ? c_tap_tlr : tap_next(r_tap_state, r_tms);
            // Captured bits enter at the MSB and are right-aligned at the end
            if (r_state == c_st_shift) begin
               r_tdo_sr <= {tdo, r_tdo_sr[MAX_LEN-1:1]};
               r_tdi_sr <= r_tdi_sr >> 1;
            end
         end
         if (w_finish_scan) r_rsp_data <= r_tdo_sr >> (c_max_len - r_len);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_master
//  Purpose  : Directed bench for jtag_master with a behavioural 4-bit-IR TAP
//             (IR capture 0001, BYPASS = 1111, DR always bypass) and a
//             pin-level monitor logging TMS/TDI/tap_state per TCK rise.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtag_master;

   localparam int MAX_LEN = 32;
   localparam int DIV     = 4;
   localparam int LEN_W   = 6;

   localparam logic [1:0] c_reset = 2'd0, c_idle = 2'd1, c_ir = 2'd2, c_dr = 2'd3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_type = 2'd0;
   logic [LEN_W-1:0]   cmd_len = '0;
   logic [MAX_LEN-1:0] cmd_data = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [MAX_LEN-1:0] rsp_data;
   logic [3:0]         tap_state;
   logic               tck, tms, tdi, trst;
   logic               tdo;

   int n_checks = 0;
   int n_errors = 0;

   jtag_master #(.MAX_LEN(MAX_LEN), .DIV(DIV), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .tap_state(tap_state),
      .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural TAP ----------------
   logic [3:0] m_state = 4'hF;
   logic [3:0] m_ir    = 4'h1;
   logic [3:0] m_ir_sr = 4'h0;
   logic       m_byp   = 1'b0;

   function automatic logic [3:0] m_next(input logic [3:0] s, input logic t);
      case (s)
         4'hF: return t ? 4'hF : 4'hC;   4'hC: return t ? 4'h7 : 4'hC;
         4'h7: return t ? 4'h4 : 4'h6;   4'h6: return t ? 4'h1 : 4'h2;
         4'h2: return t ? 4'h1 : 4'h2;   4'h1: return t ? 4'h5 : 4'h3;
         4'h3: return t ? 4'h0 : 4'h3;   4'h0: return t ? 4'h5 : 4'h2;
         4'h5: return t ? 4'h7 : 4'hC;   4'h4: return t ? 4'hF : 4'hE;
         4'hE: return t ? 4'h9 : 4'hA;   4'hA: return t ? 4'h9 : 4'hA;
         4'h9: return t ? 4'hD : 4'hB;   4'hB: return t ? 4'h8 : 4'hB;
         4'h8: return t ? 4'hD : 4'hA;   default: return t ? 4'h7 : 4'hC;
      endcase
   endfunction

   always @(posedge tck or posedge trst) begin
      if (trst) begin
         m_state <= 4'hF;
         m_ir    <= 4'h1;
      end else begin
         case (m_state)
            4'hE: m_ir_sr <= 4'b0001;
            4'hA: m_ir_sr <= {tdi, m_ir_sr[3:1]};
            4'hD: m_ir    <= m_ir_sr;
            4'hF: m_ir    <= 4'h1;
            4'h6: m_byp   <= 1'b0;
            4'h2: m_byp   <= tdi;
            default: ;
         endcase
         m_state <= m_next(m_state, tms);
      end
   end

   assign tdo = (m_state == 4'hA) ? m_ir_sr[0] : (m_state == 4'h2) ? m_byp : 1'b0;

   // ---------------- pin monitor ----------------
   bit         tms_q[$];
   bit         tdi_q[$];
   logic [3:0] st_q[$];
   int         trst_cnt = 0;

   always @(posedge tck) begin
      tms_q.push_back(tms);
      tdi_q.push_back(tdi);
      #1 st_q.push_back(tap_state);
   end

   always @(negedge clk) if (trst) trst_cnt++;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input bit q[$], input int start);
      logic [63:0] r = '0;
      for (int i = start; i < q.size() && i - start < 64; i++) r[i - start] = q[i];
      return r;
   endfunction

   task automatic send_cmd(input logic [1:0] t, input logic [LEN_W-1:0] n, input logic [MAX_LEN-1:0] d);
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
      end
      if (!ok) check("cmd_ready_timeout", 0, 1);
      cmd_type  = t;
      cmd_len   = n;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = rsp_valid;
      end
      if (!ok) check("rsp_valid_timeout", 0, 1);
   endtask

   task automatic take_rsp(output logic [MAX_LEN-1:0] d);
      wait_rsp_valid();
      d = rsp_data;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
      end
      check(tag, ok, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [MAX_LEN-1:0] d;
      int s, tc, bad;
      logic [MAX_LEN-1:0] hd;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_tck", tck, 0);
      check("rst_tms", tms, 1);
      check("rst_tdi", tdi, 0);
      check("rst_trst", trst, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_tap_state", tap_state, 4'hF);

      // power-up sequence
      s = tms_q.size();
      rst_n = 1'b1;
      wait_ready("pwr_ready");
      check("pwr_ntck", tms_q.size() - s, 6);
      check("pwr_tms", pack(tms_q, s), 64'h1F);
      check("pwr_tap_state", tap_state, 4'hC);
      check("pwr_model_state", m_state, 4'hC);

      // IR scan, 4 bits 1001
      s = tms_q.size();
      send_cmd(c_ir, 6'd4, 32'h9);
      take_rsp(d);
      check("ir_rsp", d, 32'h1);
      check("ir_ntck", tms_q.size() - s, 10);
      check("ir_tms", pack(tms_q, s), 64'h183);
      check("ir_tdi", pack(tdi_q, s), 64'h90);
      check("ir_model_ir", m_ir, 4'h9);
      check("ir_tap_state", tap_state, 4'hC);

      // IR BYPASS then DR scan 8 bits A5
      send_cmd(c_ir, 6'd4, 32'hF);
      take_rsp(d);
      check("byp_ir_rsp", d, 32'h1);
      check("byp_model_ir", m_ir, 4'hF);
      s = tms_q.size();
      send_cmd(c_dr, 6'd8, 32'hA5);
      take_rsp(d);
      check("dr_rsp", d, 32'h4A);
      check("dr_ntck", tms_q.size() - s, 13);
      check("dr_tms", pack(tms_q, s), 64'hC01);
      check("dr_tdi", pack(tdi_q, s), 64'h528);
      check("dr_tap_state", tap_state, 4'hC);

      // response held off for 20 clocks
      send_cmd(c_dr, 6'd8, 32'h3C);
      wait_rsp_valid();
      hd  = rsp_data;
      tc  = tms_q.size();
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== hd || cmd_ready || tck) bad++;
      end
      check("hold_stable", bad, 0);
      check("hold_data", hd, 32'h78);
      check("hold_no_tck", tms_q.size() - tc, 0);
      take_rsp(d);

      // zero-length DR scan: immediate response, no TCK
      s = tms_q.size();
      send_cmd(c_dr, 6'd0, 32'hFFFF);
      check("dr0_rsp_fast", rsp_valid, 1);
      take_rsp(d);
      check("dr0_rsp", d, 0);
      check("dr0_ntck", tms_q.size() - s, 0);

      // RESET command from RTI
      s  = tms_q.size();
      tc = trst_cnt;
      send_cmd(c_reset, 6'd0, 32'h0);
      take_rsp(d);
      check("rstcmd_rsp", d, 0);
      check("rstcmd_ntck", tms_q.size() - s, 6);
      check("rstcmd_tms", pack(tms_q, s), 64'h1F);
      check("rstcmd_trst_len", trst_cnt - tc, 2 * DIV);
      check("rstcmd_state5", st_q[s + 4], 4'hF);
      check("rstcmd_tap_state", tap_state, 4'hC);
      check("rstcmd_model_state", m_state, 4'hC);

      // IDLE 0 and IDLE 3
      s = tms_q.size();
      send_cmd(c_idle, 6'd0, 32'h0);
      check("idle0_rsp_fast", rsp_valid, 1);
      take_rsp(d);
      check("idle0_ntck", tms_q.size() - s, 0);
      s = tms_q.size();
      send_cmd(c_idle, 6'd3, 32'h0);
      take_rsp(d);
      check("idle3_ntck", tms_q.size() - s, 3);
      check("idle3_tms", pack(tms_q, s), 0);
      check("idle3_rsp", d, 0);

      // oversize length clamps to MAX_LEN through bypass
      send_cmd(c_ir, 6'd4, 32'hF);
      take_rsp(d);
      s = tms_q.size();
      send_cmd(c_dr, 6'd40, 32'h8000_0001);
      take_rsp(d);
      check("clamp_ntck", tms_q.size() - s, 3 + 32 + 2);
      check("clamp_rsp", d, 32'h0000_0002);

      // reset in the middle of a DR shift
      send_cmd(c_dr, 6'd8, 32'hFF);
      bad = 1;
      for (int i = 0; i < 3000 && bad == 1; i++) begin
         @(negedge clk);
         if (m_state == 4'h2) bad = 0;
      end
      check("mid_reach_shift", bad, 0);
      repeat (13) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_tck", tck, 0);
      check("mid_tms", tms, 1);
      check("mid_tdi", tdi, 0);
      check("mid_trst", trst, 0);
      check("mid_cmd_ready", cmd_ready, 0);
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_rsp_data", rsp_data, 0);
      check("mid_tap_state", tap_state, 4'hF);
      repeat (3) @(negedge clk);
      s = tms_q.size();
      rst_n = 1'b1;
      wait_ready("rec_ready");
      check("rec_ntck", tms_q.size() - s, 6);
      check("rec_tms", pack(tms_q, s), 64'h1F);
      check("rec_tap_state", tap_state, 4'hC);
      check("rec_model_state", m_state, 4'hC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
